// File: rtl/aes_inv_key_sched.sv
// AES-128 key scheduler that hands out round keys in decryption order.
// The forward schedule runs once to reach round 10. The inverse recurrence then
// walks back to round 0, one key per valid/ready transfer.

package aes_package;
  parameter int DATA_WIDTH    = 128;
  parameter int WORD_SIZE     = 32;
  parameter int NUM_OF_ROUNDS = 10;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX_TBL[idx +: 8];
  endfunction
endpackage

module aes_inv_key_sched
  import aes_package::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic [DATA_WIDTH-1:0] key,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic [DATA_WIDTH-1:0] round_key,
  output logic [3:0]            round_idx,
  output logic                  rk_last,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_EMIT} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_k;
  logic [7:0]            r_rcon;
  logic [3:0]            r_cnt;
  logic [3:0]            r_round_idx;
  logic                  r_rk_valid;
  logic                  r_rk_last;
  logic                  r_busy;

  logic [WORD_SIZE-1:0]  w_w0, w_w1, w_w2, w_w3;
  logic [WORD_SIZE-1:0]  w_inv1, w_inv2, w_inv3;
  logic [WORD_SIZE-1:0]  w_g_in, w_rot, w_g;
  logic [WORD_SIZE-1:0]  w_f0, w_f1, w_f2, w_f3;
  logic [DATA_WIDTH-1:0] w_fwd, w_inv;
  logic                  w_xfer;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    return r[0] ? ({1'b0, r[7:1]} ^ 8'h8d) : {1'b0, r[7:1]};
  endfunction

  // Shared g() feeds both directions: the forward step uses w3, the inverse
  // step uses the already-recovered w3' = w3 ^ w2.
  always_comb begin
    w_w0   = r_k[127:96];
    w_w1   = r_k[95:64];
    w_w2   = r_k[63:32];
    w_w3   = r_k[31:0];
    w_inv3 = w_w3 ^ w_w2;
    w_inv2 = w_w2 ^ w_w1;
    w_inv1 = w_w1 ^ w_w0;
    w_g_in = (r_state == S_EMIT) ? w_inv3 : w_w3;
    w_rot  = {w_g_in[23:0], w_g_in[31:24]};
    w_g    = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
              sbox(w_rot[15:8]),  sbox(w_rot[7:0])} ^ {r_rcon, 24'h0};
    w_f0   = w_w0 ^ w_g;
    w_f1   = w_w1 ^ w_f0;
    w_f2   = w_w2 ^ w_f1;
    w_f3   = w_w3 ^ w_f2;
    w_fwd  = {w_f0, w_f1, w_f2, w_f3};
    w_inv  = {w_w0 ^ w_g, w_inv1, w_inv2, w_inv3};
  end

  assign w_xfer    = r_rk_valid & rk_ready;
  assign key_ready = (r_state == S_IDLE);
  assign rk_valid  = r_rk_valid;
  assign round_key = r_k;
  assign round_idx = r_round_idx;
  assign rk_last   = r_rk_last;
  assign busy      = r_busy;

  // Control FSM: load, 10 forward steps, then one inverse step per transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_rcon      <= '0;
      r_cnt       <= '0;
      r_round_idx <= '0;
      r_rk_valid  <= 1'b0;
      r_rk_last   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (key_valid) begin
            r_k     <= key;
            r_rcon  <= 8'h01;
            r_cnt   <= 4'd1;
            r_busy  <= 1'b1;
            r_state <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          r_k <= w_fwd;
          if (r_cnt != 4'(NUM_OF_ROUNDS)) begin
            r_rcon <= xtime(r_rcon);
            r_cnt  <= r_cnt + 4'd1;
          end else begin
            // rcon stays at 8'h36, which is exactly what the first inverse step needs
            r_round_idx <= 4'(NUM_OF_ROUNDS);
            r_rk_valid  <= 1'b1;
            r_rk_last   <= 1'b0;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_xfer) begin
            if (r_round_idx != 4'd0) begin
              r_k         <= w_inv;
              r_rcon      <= inv_xtime(r_rcon);
              r_round_idx <= r_round_idx - 4'd1;
              r_rk_last   <= (r_round_idx == 4'd1);
            end else begin
              r_rk_valid <= 1'b0;
              r_rk_last  <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: a software key expansion (S-box built from the
// GF(2^8) inverse and the affine map) supplies every expected round key.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst, key_valid, key_ready, rk_valid, rk_ready, rk_last, busy;
  logic [127:0] key, round_key;
  logic [3:0]   round_idx;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_inv_key_sched dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key(key),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .round_key(round_key),
    .round_idx(round_idx), .rk_last(rk_last), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0]   sb [0:255];
  logic [127:0] exp_rk [0:10];
  int           exp_idx, n_xfer, total, bad;
  bit           armed, done, chk_drop, stop, rnd_ready;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] x, y;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i); y = 8'h01;
      repeat (254) y = gmul(y, x);   // x^254 = x^-1, and 0 maps to 0
      sb[i] = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    end
  endtask

  task automatic build_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[(3-i)*32 +: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Load one key (caller sits just after a rising edge) and follow it to rk_last.
  task automatic run_key(input logic [127:0] k, input bit ign, input logic [127:0] kb);
    int n, cyc;
    build_model(k);
    exp_idx = 10; n_xfer = 0; done = 1'b0; armed = 1'b1;
    key = k; key_valid = 1'b1;
    @(negedge clk);
    chk("key_ready_idle", 128'(key_ready), 128'(1));
    @(posedge clk); #1;
    if (ign) key = kb;
    else begin key_valid = 1'b0; key = ~k; end
    n = 0;
    while (!rk_valid && n < 20) begin
      chk("key_ready_expand", 128'(key_ready), 128'(0));
      chk("busy_expand", 128'(busy), 128'(1));
      @(posedge clk); #1;
      n++;
    end
    // ten expand edges follow the accepting edge, so rk_valid appears on the 11th edge overall
    chk("first_valid_latency", 128'(n), 128'(10));
    cyc = 0;
    while (!done && cyc < 400) begin
      @(posedge clk);
      cyc++;
    end
    chk("seq_done", 128'(done), 128'(1));
    if (!rnd_ready) chk("emit_cycles", 128'(cyc), 128'(11));
    chk("xfer_count", 128'(n_xfer), 128'(11));
    #1;
    key_valid = 1'b0;
    armed = 1'b0;
  endtask

  initial begin
    int cyc;
    rst = 1'b0; key_valid = 1'b0; key = '0; rk_ready = 1'b1;
    total = 0; bad = 0; armed = 0; done = 0; chk_drop = 0; stop = 0; rnd_ready = 0;
    exp_idx = 0; n_xfer = 0;
    build_sbox();
    #2;
    chk("rst_key_ready", 128'(key_ready), 128'(1));
    chk("rst_rk_valid", 128'(rk_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_round_idx", 128'(round_idx), 128'(0));
    chk("rst_rk_last", 128'(rk_last), 128'(0));
    chk("rst_round_key", round_key, 128'h0);

    fork
      begin
        while (!stop) begin
          @(negedge clk);
          if (chk_drop) begin
            chk("rk_valid_drop", 128'(rk_valid), 128'(0));
            chk_drop = 1'b0;
          end
          if (armed && rk_valid) begin
            chk("round_key", round_key, exp_rk[exp_idx]);
            chk("round_idx", 128'(round_idx), 128'(exp_idx));
            chk("rk_last", 128'(rk_last), 128'(exp_idx == 0));
            chk("key_ready_emit", 128'(key_ready), 128'(0));
            chk("busy_emit", 128'(busy), 128'(1));
            if (rk_ready) begin
              n_xfer++;
              if (exp_idx == 0) begin
                armed = 1'b0; done = 1'b1; chk_drop = 1'b1;
              end else exp_idx--;
            end
          end else if (!armed && rst) begin
            chk("spurious_valid", 128'(rk_valid), 128'(0));
          end
        end
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
      begin
        #10;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // pin the reference model to published values
        build_model(FIPS_KEY);
        chk("model_fips_rk10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model_fips_rk9",  exp_rk[9],  128'hac7766f319fadc2128d12941575c006e);
        chk("model_fips_rk1",  exp_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
        chk("model_fips_rk0",  exp_rk[0],  FIPS_KEY);
        build_model(128'h0);
        chk("model_zero_rk10", exp_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        run_key(FIPS_KEY, 1'b0, 128'h0);
        run_key(128'h0, 1'b0, 128'h0);

        rnd_ready = 1'b1;
        run_key(FIPS_KEY, 1'b0, 128'h0);
        run_key(FIPS_KEY, 1'b1, 128'h00112233445566778899aabbccddeeff);
        rnd_ready = 1'b0;
        @(posedge clk); #1;
        run_key(FIPS_KEY, 1'b1, 128'hffeeddccbbaa99887766554433221100);

        // reset in the middle of the emit phase
        build_model(FIPS_KEY);
        exp_idx = 10; n_xfer = 0; done = 1'b0; armed = 1'b1;
        key = FIPS_KEY; key_valid = 1'b1;
        @(posedge clk); #1 key_valid = 1'b0;
        cyc = 0;
        while (!(rk_valid && round_idx == 4'd5) && cyc < 100) begin
          @(posedge clk); #1;
          cyc++;
        end
        chk("reached_idx5", 128'(round_idx), 128'(5));
        armed = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_rk_valid", 128'(rk_valid), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_round_idx", 128'(round_idx), 128'(0));
        chk("midrst_key_ready", 128'(key_ready), 128'(1));
        chk("midrst_round_key", round_key, 128'h0);
        @(posedge clk); #1;
        chk("midrst_hold_valid", 128'(rk_valid), 128'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        run_key(FIPS_KEY, 1'b0, 128'h0);

        // back-to-back random keys; each load starts on the cycle after rk_last transfers
        for (int i = 0; i < 200; i++)
          run_key({$urandom, $urandom, $urandom, $urandom}, 1'b0, 128'h0);

        stop = 1'b1;
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
